mem_stage: RTL and testbench

//  MIPS pipeline MEM stage: the consumer of the Execute stage outputs.
//  - Holds the EX/MEM pipeline register.
//  - Drives a req/ack data-memory port for lw/sw, with a stall back to the upstream stages.
//  - Resolves branches (PCSrc = Branch & zero).
//  - Loads the MEM/WB pipeline register for the write-back stage.

---
 rtl/mem_stage_if.sv | 13 +
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port used by the MEM stage.
// The master drives a request and waits for ack; the slave returns read data with ack.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, output we, output addr, output wdata, input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM register, req/ack data-memory access with stall and timeout,
// branch resolution and the MEM/WB register.
module mem_stage #(
  parameter int unsigned Timeout = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         adder_branch_result_i,
  input  logic                alu_zero_i,
  input  logic [31:0]         alu_result_i,
  input  logic [4:0]          reg_write_reg_i,
  input  logic [31:0]         temp_regfile_2_i,
  input  logic [2:0]          sigs_mem_i,
  input  logic [1:0]          sigs_wb_i,
  mem_stage_if.master         dmem,
  output logic                stall_o,
  output logic                pc_src_o,
  output logic [31:0]         branch_target_o,
  output logic [31:0]         read_data_o,
  output logic [31:0]         alu_result_o,
  output logic [4:0]          reg_write_reg_o,
  output logic [1:0]          sigs_wb_o,
  output logic                err_o
);

  localparam int unsigned CntW = (Timeout > 2) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic [31:0] target_q, alu_q, rd2_q;
  logic        zero_q, branch_q, mem_read_q, mem_write_q;
  logic [4:0]  wreg_q;
  logic [1:0]  sigs_wb_q;

  logic [31:0] wb_alu_q, wb_rdata_q, wb_rdata_d;
  logic [4:0]  wb_wreg_q;
  logic [1:0]  wb_sigs_q, wb_sigs_d;
  logic        err_q;

  logic access, last, stall, load, timeout, memop, misal, in_ok, read_ok;

  always_comb begin
    access  = (state_q == StAccess);
    last    = (cnt_q == CntLast);
    stall   = access & ~dmem.ack & ~last;
    load    = ~stall;
    timeout = access & ~dmem.ack & last;
    memop   = mem_read_q | mem_write_q;
    misal   = memop & (alu_q[1:0] != 2'b00);
    in_ok   = (sigs_mem_i[1] | sigs_mem_i[0]) & (alu_result_i[1:0] == 2'b00);
    // Write wins when both read and write are flagged, so no load data then.
    read_ok = access & mem_read_q & ~mem_write_q & dmem.ack;
  end

  // Re-entry into StAccess happens naturally: any load edge re-evaluates the incoming entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= in_ok ? StAccess : StIdle;
      cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      zero_q      <= 1'b0;
      alu_q       <= '0;
      wreg_q      <= '0;
      rd2_q       <= '0;
      branch_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      sigs_wb_q   <= '0;
    end else if (load) begin
      target_q    <= adder_branch_result_i;
      zero_q      <= alu_zero_i;
      alu_q       <= alu_result_i;
      wreg_q      <= reg_write_reg_i;
      rd2_q       <= temp_regfile_2_i;
      branch_q    <= sigs_mem_i[2];
      mem_read_q  <= sigs_mem_i[1];
      mem_write_q <= sigs_mem_i[0];
      sigs_wb_q   <= sigs_wb_i;
    end
  end

  always_comb begin
    wb_rdata_d = read_ok ? dmem.rdata : 32'h0;
    wb_sigs_d  = sigs_wb_q;
    if (timeout) begin
      wb_sigs_d = 2'b00;
    end else if (misal) begin
      wb_sigs_d = {1'b0, sigs_wb_q[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_alu_q   <= '0;
      wb_wreg_q  <= '0;
      wb_rdata_q <= '0;
      wb_sigs_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (load) begin
        wb_alu_q   <= alu_q;
        wb_wreg_q  <= wreg_q;
        wb_rdata_q <= wb_rdata_d;
        wb_sigs_q  <= wb_sigs_d;
      end else begin
        wb_sigs_q  <= 2'b00;
      end
      if (timeout | misal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign dmem.req        = access;
  assign dmem.we         = mem_write_q;
  assign dmem.addr       = alu_q;
  assign dmem.wdata      = rd2_q;
  assign stall_o         = stall;
  assign pc_src_o        = branch_q & zero_q & ~stall;
  assign branch_target_o = target_q;
  assign read_data_o     = wb_rdata_q;
  assign alu_result_o    = wb_alu_q;
  assign reg_write_reg_o = wb_wreg_q;
  assign sigs_wb_o       = wb_sigs_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, stalled and 1-cycle
// loads/stores, timeout, misalignment, branches and reset during an access.
module tb_mem_stage;
  logic        clk;
  logic        rst;
  logic [31:0] target;
  logic        zero;
  logic [31:0] alu;
  logic [4:0]  wreg;
  logic [31:0] rd2;
  logic [2:0]  smem;
  logic [1:0]  swb;
  logic        stall, pc_src, err;
  logic [31:0] btarget, rdata_o, alu_o;
  logic [4:0]  wreg_o;
  logic [1:0]  swb_o;

  int checks = 0;
  int errors = 0;
  int cycles;
  int stalls;

  mem_stage_if dmem_if ();

  mem_stage #(.Timeout(16)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .adder_branch_result_i (target),
    .alu_zero_i            (zero),
    .alu_result_i          (alu),
    .reg_write_reg_i       (wreg),
    .temp_regfile_2_i      (rd2),
    .sigs_mem_i            (smem),
    .sigs_wb_i             (swb),
    .dmem                  (dmem_if),
    .stall_o               (stall),
    .pc_src_o              (pc_src),
    .branch_target_o       (btarget),
    .read_data_o           (rdata_o),
    .alu_result_o          (alu_o),
    .reg_write_reg_o       (wreg_o),
    .sigs_wb_o             (swb_o),
    .err_o                 (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [2:0] m, input logic [1:0] w, input logic [31:0] a,
                        input logic [4:0] r, input logic [31:0] d, input logic z,
                        input logic [31:0] t);
    smem = m; swb = w; alu = a; wreg = r; rd2 = d; zero = z; target = t;
  endtask

  task automatic nop();
    set_ex(3'b000, 2'b00, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    dmem_if.ack = 1'b0;
    dmem_if.rdata = 32'h0;
    nop();
    #2;
    chk("rst_req", dmem_if.req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pcsrc", pc_src, 0);
    chk("rst_err", err, 0);
    chk("rst_sigswb", swb_o, 0);
    chk("rst_alu", alu_o, 0);
    #1 rst = 1'b0;

    // ALU op passes through both pipeline registers
    set_ex(3'b000, 2'b10, 32'h1234, 5'd5, 32'h0, 1'b0, 32'h0);
    tick();
    nop();
    #1;
    chk("alu_req", dmem_if.req, 0);
    chk("alu_stall", stall, 0);
    tick();
    chk("alu_result", alu_o, 32'h1234);
    chk("alu_wreg", wreg_o, 5);
    chk("alu_sigswb", swb_o, 2'b10);

    // lw with ack on the 3rd access cycle
    set_ex(3'b010, 2'b11, 32'h40, 5'd7, 32'h0, 1'b0, 32'h0);
    tick();
    set_ex(3'b000, 2'b10, 32'h55, 5'd9, 32'h0, 1'b0, 32'h0);
    #1;
    chk("lw_req", dmem_if.req, 1);
    chk("lw_we", dmem_if.we, 0);
    chk("lw_addr", dmem_if.addr, 32'h40);
    chk("lw_stall1", stall, 1);
    tick();
    chk("lw_bubble1", swb_o, 0);
    chk("lw_stall2", stall, 1);
    chk("lw_addr2", dmem_if.addr, 32'h40);
    tick();
    chk("lw_bubble2", swb_o, 0);
    dmem_if.ack = 1'b1;
    dmem_if.rdata = 32'hDEADBEEF;
    #1;
    chk("lw_ackstall", stall, 0);
    tick();
    dmem_if.ack = 1'b0;
    dmem_if.rdata = 32'h0;
    chk("lw_rdata", rdata_o, 32'hDEADBEEF);
    chk("lw_sigswb", swb_o, 2'b11);
    chk("lw_wreg", wreg_o, 7);
    chk("lw_reqoff", dmem_if.req, 0);
    nop();
    tick();
    chk("lw_next_alu", alu_o, 32'h55);
    chk("lw_next_rdata", rdata_o, 0);

    // sw then lw, both acked in their first cycle
    dmem_if.ack = 1'b1;
    dmem_if.rdata = 32'h11112222;
    set_ex(3'b001, 2'b00, 32'h80, 5'd0, 32'hCAFEF00D, 1'b0, 32'h0);
    tick();
    set_ex(3'b010, 2'b11, 32'h84, 5'd3, 32'h0, 1'b0, 32'h0);
    #1;
    chk("sw_req", dmem_if.req, 1);
    chk("sw_we", dmem_if.we, 1);
    chk("sw_wdata", dmem_if.wdata, 32'hCAFEF00D);
    chk("sw_addr", dmem_if.addr, 32'h80);
    chk("sw_stall", stall, 0);
    tick();
    nop();
    #1;
    chk("sw_rdata", rdata_o, 0);
    chk("b2b_req", dmem_if.req, 1);
    chk("b2b_we", dmem_if.we, 0);
    chk("b2b_addr", dmem_if.addr, 32'h84);
    chk("b2b_stall", stall, 0);
    tick();
    dmem_if.ack = 1'b0;
    chk("b2b_rdata", rdata_o, 32'h11112222);
    chk("b2b_sigswb", swb_o, 2'b11);
    chk("b2b_wreg", wreg_o, 3);
    chk("b2b_reqoff", dmem_if.req, 0);

    // Timeout: no ack at all
    set_ex(3'b010, 2'b11, 32'h100, 5'd4, 32'h0, 1'b0, 32'h0);
    tick();
    nop();
    cycles = 0;
    stalls = 0;
    while (dmem_if.req === 1'b1 && cycles < 40) begin
      if (stall) stalls++;
      cycles++;
      tick();
    end
    chk("to_cycles", cycles, 16);
    chk("to_stalls", stalls, 15);
    chk("to_sigswb", swb_o, 0);
    chk("to_rdata", rdata_o, 0);
    chk("to_alu", alu_o, 32'h100);
    chk("to_err", err, 1);

    // Clear the sticky error before the misaligned case
    rst = 1'b1;
    #1;
    chk("clr_err", err, 0);
    rst = 1'b0;

    // Misaligned lw
    set_ex(3'b010, 2'b11, 32'h41, 5'd6, 32'h0, 1'b0, 32'h0);
    tick();
    nop();
    #1;
    chk("mis_req", dmem_if.req, 0);
    chk("mis_stall", stall, 0);
    tick();
    chk("mis_err", err, 1);
    chk("mis_sigswb", swb_o, 2'b01);
    chk("mis_rdata", rdata_o, 0);

    // Branches
    set_ex(3'b100, 2'b00, 32'h0, 5'd0, 32'h0, 1'b1, 32'h100);
    tick();
    chk("beq_taken", pc_src, 1);
    chk("beq_target", btarget, 32'h100);
    set_ex(3'b100, 2'b00, 32'h4, 5'd0, 32'h0, 1'b0, 32'h200);
    tick();
    chk("beq_nottaken", pc_src, 0);
    chk("beq_target2", btarget, 32'h200);

    // Branch combined with a memop is masked while stalled
    set_ex(3'b110, 2'b00, 32'h10, 5'd0, 32'h0, 1'b1, 32'h300);
    tick();
    nop();
    #1;
    chk("brmem_masked", pc_src, 0);
    dmem_if.ack = 1'b1;
    #1;
    chk("brmem_unmasked", pc_src, 1);
    tick();
    dmem_if.ack = 1'b0;

    // Reset during the second access cycle
    set_ex(3'b010, 2'b11, 32'h40, 5'd8, 32'h0, 1'b0, 32'h0);
    tick();
    nop();
    tick();
    chk("rma_req_before", dmem_if.req, 1);
    rst = 1'b1;
    #1;
    chk("rma_req", dmem_if.req, 0);
    chk("rma_stall", stall, 0);
    chk("rma_err", err, 0);
    chk("rma_alu", alu_o, 0);
    chk("rma_wreg", wreg_o, 0);
    chk("rma_sigswb", swb_o, 0);
    #1 rst = 1'b0;
    dmem_if.ack = 1'b1;
    dmem_if.rdata = 32'h99;
    tick();
    dmem_if.ack = 1'b0;
    chk("late_ack_rdata", rdata_o, 0);
    chk("late_ack_sigswb", swb_o, 0);
    chk("late_ack_req", dmem_if.req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
